preta_deconv_row_drain: RTL and testbench
=========================================

PRETA_DECONV_ROW_DRAIN -- requirements
Module: preta_deconv_row_drain

Interface
REQ-001 Parameter DATA_W, default 16, output sample width (signed).
REQ-002 Parameter ACC_W, default DATA_W+6, input accumulator width (signed).
REQ-003 Parameter SHIFT, default 6, right-shift applied during requantisation; range 0..ACC_W-1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 valid_in  input  1  6x6 deconv patch present on patch_in_flat this cycle; there is no upstream stall.
REQ-007 patch_in_flat  input  ACC_W*36  6x6 patch, element (r,c) at bits [(r*6+c)*ACC_W +: ACC_W].
REQ-008 in_ready  output  1  buffer can accept a patch this cycle.
REQ-009 out_valid  output  1  row_out_flat holds a valid row.
REQ-010 out_ready  input  1  downstream accepts the current row.
REQ-011 row_out_flat  output  DATA_W*6  one requantised row, column c at bits [c*DATA_W +: DATA_W].
REQ-012 row_idx  output  3  index 0..5 of the presented row within its patch.
REQ-013 last_row  output  1  out_valid and row_idx==5.
REQ-014 overflow_err  output  1  sticky; a patch arrived while the buffer was full.
REQ-015 clear_err  input  1  clears overflow_err.

Function
REQ-016 Storage: two-entry patch FIFO (ping-pong), occupancy count 0..2, write pointer, read pointer.
REQ-017 in_ready = rst_n && count<2, computed from registered state only.
REQ-018 valid_in && count<2: patch written to entry wr_ptr at the edge; wr_ptr toggles.
REQ-019 valid_in && count==2: patch discarded and overflow_err set, even if the final row pops in the same cycle.
REQ-020 out_valid = count>0; row_out_flat and row_idx present entry rd_ptr, row row_idx.
REQ-021 Latency: a patch captured at edge k is visible at out_valid/row_idx=0 in the cycle after edge k when the FIFO was empty.
REQ-022 Handshake: a row transfers on out_valid && out_ready; outputs hold stable while out_valid && !out_ready.
REQ-023 On transfer, row_idx increments; at row_idx==5 it wraps to 0, the entry is popped, rd_ptr toggles and count decrements.
REQ-024 Push and final-row pop in the same cycle leave count unchanged and are both performed.
REQ-025 Requantisation per element: if SHIFT>0, add 2^(SHIFT-1) in ACC_W+1 bits, then arithmetic right shift by SHIFT; if SHIFT==0, no rounding is applied.
REQ-026 Saturation: the shifted value is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-027 Requantisation is combinational from stored data; no added cycle.
REQ-028 clear_err has priority over a simultaneous overflow set (overflow_err ends 0).
REQ-029 Rows exit in order 0..5 and patches exit in arrival order; there is no reordering.

Reset
REQ-030 While rst_n is low at an edge: count, wr_ptr, rd_ptr and row_idx become 0, and overflow_err becomes 0.
REQ-031 After reset: out_valid=0 and last_row=0; in_ready=0 while rst_n is low and 1 afterwards.
REQ-032 Reset during a drain discards all buffered patches; no partial row is emitted afterwards.
REQ-033 Patch storage is not reset; its contents are don't-care when count==0.

Structure
REQ-034 Shared package preta_pkg holds the DATA_W/ACC_W defaults, the patch dimension constants (6 rows, 6 columns) and the round/saturate limit constants.
REQ-035 The sub-module preta_round_sat (combinational, ACC_W to DATA_W, parameter SHIFT) is instantiated 6 times, once per column.
REQ-036 The block connects directly to the valid_out/patch_out_flat outputs of the existing deconv stage.

Verification
REQ-037 Single patch: element (r,c)=(r*6+c)*64, SHIFT=6, out_ready=1 -> 6 consecutive rows; row r is r*6..r*6+5; last_row on the 6th row; in_ready stays 1.
REQ-038 Rounding/saturation, SHIFT=6, DATA_W=16: inputs 32, 31, -32, -33, 2^21-1, -2^21 -> outputs 1, 0, 0, -1, 32767, -32768.
REQ-039 Backpressure: out_ready held 0 for 10 cycles mid-patch -> row_idx and row_out_flat are stable throughout; the row is released on the first cycle out_ready=1.
REQ-040 Overflow: three patches on consecutive cycles with out_ready=0 -> first two are stored, third is dropped; overflow_err=1; in_ready=0 at the third; the stored patches drain in order.
REQ-041 Simultaneous push and pop: count=2, out_ready=1, final row popping while valid_in asserts -> patch dropped and overflow_err set; count=1, row 5 popping while valid_in asserts -> count stays 1 and the new patch follows.
REQ-042 Reset mid-drain at row_idx=3 with count=2 -> next cycle out_valid=0, row_idx=0, overflow_err=0; a fresh patch then drains from row 0.

Source files
------------

// File: rtl/preta_deconv_row_drain_pkg.sv
// Shared widths, patch geometry and round/saturate limits for the deconv row drain.
// Combinational helpers only, with no storage and no handshake.
package preta_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ACC_W_DEF   = DATA_W_DEF + 6;
  localparam int SHIFT_DEF   = 6;
  localparam int PATCH_ROWS  = 6;
  localparam int PATCH_COLS  = 6;
  localparam int PATCH_ELEMS = PATCH_ROWS * PATCH_COLS;
  localparam int FIFO_DEPTH  = 2;

  localparam logic [2:0] LAST_ROW_IDX = 3'(PATCH_ROWS - 1);

  function automatic longint sat_hi(int w);
    return (longint'(1) << (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(int w);
    return -(longint'(1) << (w - 1));
  endfunction

  // Half-LSB bias for round-half-up; zero when nothing is shifted out.
  function automatic longint round_bias(int s);
    return (s > 0) ? (longint'(1) << (s - 1)) : 64'sd0;
  endfunction

endpackage

// File: rtl/preta_deconv_row_drain_if.sv
// Patch-in / row-out handshake bundle of the deconv row drain.
// Input side has no stall; the output side is valid/ready.
interface preta_deconv_row_drain_if #(
  parameter int DATA_W = preta_pkg::DATA_W_DEF,
  parameter int ACC_W  = DATA_W + 6
);
  import preta_pkg::*;

  logic                          valid_in;
  logic [ACC_W*PATCH_ELEMS-1:0]  patch_in_flat;
  logic                          in_ready;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_W*PATCH_COLS-1:0]  row_out_flat;
  logic [2:0]                    row_idx;
  logic                          last_row;

  modport slave (
    input  valid_in, patch_in_flat, out_ready,
    output in_ready, out_valid, row_out_flat, row_idx, last_row
  );

  modport master (
    output valid_in, patch_in_flat, out_ready,
    input  in_ready, out_valid, row_out_flat, row_idx, last_row
  );

endinterface

// File: rtl/preta_deconv_row_drain_round_sat.sv
// Requantise one accumulator: round-half-up, arithmetic shift, clamp to DATA_W.
// Purely combinational; zero latency, no handshake.
module preta_round_sat import preta_pkg::*; #(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] q
);

  localparam logic signed [ACC_W:0] HI   = (ACC_W+1)'(sat_hi(DATA_W));
  localparam logic signed [ACC_W:0] LO   = (ACC_W+1)'(sat_lo(DATA_W));
  localparam logic signed [ACC_W:0] BIAS = (ACC_W+1)'(round_bias(SHIFT));

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;

  // One guard bit keeps the bias add from wrapping at the positive extreme.
  assign biased  = {acc[ACC_W-1], acc} + BIAS;
  assign shifted = biased >>> SHIFT;

  always_comb begin
    q = shifted[DATA_W-1:0];
    if (shifted > HI) begin
      q = HI[DATA_W-1:0];
    end else if (shifted < LO) begin
      q = LO[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/preta_deconv_row_drain.sv
// Two-entry patch buffer draining each 6x6 patch as six requantised rows; a patch written
// into an empty buffer is presented the next cycle; rows hold under !out_ready, full buffer drops and flags.
module preta_deconv_row_drain import preta_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = DATA_W + 6,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  preta_deconv_row_drain_if.slave   io,
  input  logic                      clear_err,
  output logic                      overflow_err
);

  localparam int PATCH_W = ACC_W * PATCH_ELEMS;
  localparam int ROW_W   = ACC_W * PATCH_COLS;

  logic [PATCH_W-1:0] store [FIFO_DEPTH];

  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [2:0] row_sel;

  logic has_room, occupied, push, drop, xfer, pop;
  logic [ROW_W-1:0]             cur_row;
  logic [DATA_W*PATCH_COLS-1:0] row_q;

  assign has_room = (count != 2'd2);
  assign occupied = (count != 2'd0);
  assign push     = io.valid_in && has_room;
  assign drop     = io.valid_in && !has_room;
  assign xfer     = occupied && io.out_ready;
  assign pop      = xfer && (row_sel == LAST_ROW_IDX);

  assign io.in_ready     = rst_n && has_room;
  assign io.out_valid    = occupied;
  assign io.row_idx      = row_sel;
  assign io.last_row     = occupied && (row_sel == LAST_ROW_IDX);
  assign io.row_out_flat = row_q;

  always_ff @(posedge clk) begin
    if (push) begin
      store[wr_ptr] <= io.patch_in_flat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count        <= 2'd0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      row_sel      <= 3'd0;
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (xfer) begin
        if (row_sel == LAST_ROW_IDX) begin
          row_sel <= 3'd0;
          rd_ptr  <= ~rd_ptr;
        end else begin
          row_sel <= row_sel + 3'd1;
        end
      end
      // A simultaneous push and final-row pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (clear_err) begin
        overflow_err <= 1'b0;
      end else if (drop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  assign cur_row = store[rd_ptr][int'(row_sel)*ROW_W +: ROW_W];

  for (genvar c = 0; c < PATCH_COLS; c++) begin : g_col
    preta_round_sat #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W),
      .SHIFT  (SHIFT)
    ) u_round_sat (
      .acc (cur_row[c*ACC_W +: ACC_W]),
      .q   (row_q[c*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_preta_deconv_row_drain.sv
// Directed and random stimulus for the row drain against a queue-based reference model.
module tb_preta_deconv_row_drain;

  localparam int DW = 16;
  localparam int AW = 22;
  localparam int SH = 6;
  localparam int PW = AW * 36;
  localparam int RW = DW * 6;

  logic clk = 1'b0;
  logic rst_n;
  logic clear_err;
  logic overflow_err;

  always #5 clk = ~clk;

  preta_deconv_row_drain_if #(.DATA_W(DW), .ACC_W(AW)) bus ();

  preta_deconv_row_drain #(.DATA_W(DW), .ACC_W(AW), .SHIFT(SH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .io           (bus),
    .clear_err    (clear_err),
    .overflow_err (overflow_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 0;

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_row(string name, logic [RW-1:0] act, logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference requantisation: floor((x + half) / 2^S), then clamp.
  function automatic longint req(longint x);
    longint d, v, q;
    d = longint'(1) << SH;
    v = x + d / 2;
    if (SH == 0) v = x;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  function automatic longint elem(logic [PW-1:0] p, int idx);
    logic signed [AW-1:0] e;
    e = p[idx*AW +: AW];
    return longint'(e);
  endfunction

  function automatic logic [RW-1:0] exp_row(logic [PW-1:0] p, int r);
    logic [RW-1:0] res;
    longint v;
    res = '0;
    for (int c = 0; c < 6; c++) begin
      v = req(elem(p, r * 6 + c));
      res[c*DW +: DW] = DW'(v);
    end
    return res;
  endfunction

  function automatic longint col(int c);
    logic signed [DW-1:0] v;
    v = bus.row_out_flat[c*DW +: DW];
    return longint'(v);
  endfunction

  // Behavioural model: a queue of whole patches plus the row cursor of the head patch.
  logic [PW-1:0] mq[$];
  int  m_row = 0;
  bit  m_ovf = 0;
  bit  m_push, m_drop;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_row = 0;
      m_ovf = 0;
    end else begin
      m_push = bus.valid_in && (mq.size() < 2);
      m_drop = bus.valid_in && (mq.size() == 2);
      if (mq.size() > 0 && bus.out_ready) begin
        if (m_row == 5) begin
          m_row = 0;
          void'(mq.pop_front());
        end else begin
          m_row++;
        end
      end
      if (m_push) mq.push_back(bus.patch_in_flat);
      if (clear_err) m_ovf = 0;
      else if (m_drop) m_ovf = 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", bus.in_ready, longint'(rst_n && mq.size() < 2));
      chk("out_valid", bus.out_valid, longint'(mq.size() > 0));
      chk("row_idx", bus.row_idx, m_row);
      chk("last_row", bus.last_row, longint'(mq.size() > 0 && m_row == 5));
      chk("overflow_err", overflow_err, longint'(m_ovf));
      if (mq.size() > 0) chk_row("row_out", bus.row_out_flat, exp_row(mq[0], m_row));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_patch(logic [PW-1:0] p);
    bus.valid_in      = 1'b1;
    bus.patch_in_flat = p;
    step();
    bus.valid_in = 1'b0;
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", bus.out_valid, 0);
  endtask

  function automatic logic [PW-1:0] ramp_patch();
    logic [PW-1:0] p;
    for (int i = 0; i < 36; i++) p[i*AW +: AW] = AW'(i * 64);
    return p;
  endfunction

  function automatic logic [PW-1:0] rand_patch();
    logic [PW-1:0] p;
    for (int i = 0; i < 36; i++) begin
      case ($urandom % 8)
        0:       p[i*AW +: AW] = AW'((1 << 21) - 1);
        1:       p[i*AW +: AW] = AW'(1 << 21);
        2:       p[i*AW +: AW] = AW'(int'($urandom_range(0, 255)) - 128);
        default: p[i*AW +: AW] = AW'($urandom);
      endcase
    end
    return p;
  endfunction

  logic [PW-1:0] p;
  logic [RW-1:0] held;

  initial begin
    rst_n             = 1'b0;
    clear_err         = 1'b0;
    bus.valid_in      = 1'b0;
    bus.patch_in_flat = '0;
    bus.out_ready     = 1'b0;
    step();
    step();
    armed = 1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_last_row", bus.last_row, 0);
    chk("rst_row_idx", bus.row_idx, 0);
    chk("rst_overflow", overflow_err, 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", bus.in_ready, 1);

    chk("model_round_32", req(32), 1);
    chk("model_round_31", req(31), 0);
    chk("model_round_m32", req(-32), 0);
    chk("model_round_m33", req(-33), -1);
    chk("model_sat_hi", req((64'sd1 << 21) - 1), 32767);
    chk("model_sat_lo", req(-(64'sd1 << 21)), -32768);

    // Single ramp patch drains as six back-to-back rows.
    bus.out_ready = 1'b1;
    push_patch(ramp_patch());
    for (int r = 0; r < 6; r++) begin
      chk("single_valid", bus.out_valid, 1);
      chk("single_row_idx", bus.row_idx, r);
      chk("single_col0", col(0), r * 6);
      chk("single_col5", col(5), r * 6 + 5);
      chk("single_last", bus.last_row, longint'(r == 5));
      chk("single_in_ready", bus.in_ready, 1);
      step();
    end
    chk("single_done", bus.out_valid, 0);

    // Rounding and saturation corners in row 0.
    p = '0;
    p[0*AW +: AW] = AW'(32);
    p[1*AW +: AW] = AW'(31);
    p[2*AW +: AW] = AW'(-32);
    p[3*AW +: AW] = AW'(-33);
    p[4*AW +: AW] = AW'((1 << 21) - 1);
    p[5*AW +: AW] = AW'(1 << 21);
    push_patch(p);
    chk("rs_32", col(0), 1);
    chk("rs_31", col(1), 0);
    chk("rs_m32", col(2), 0);
    chk("rs_m33", col(3), -1);
    chk("rs_max", col(4), 32767);
    chk("rs_min", col(5), -32768);
    drain(20);

    // Backpressure mid-patch.
    push_patch(rand_patch());
    step();
    step();
    bus.out_ready = 1'b0;
    held = bus.row_out_flat;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_row_idx", bus.row_idx, 2);
      chk_row("bp_row_hold", bus.row_out_flat, held);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_release", bus.row_idx, 3);
    drain(20);

    // Three consecutive patches against a stalled output.
    bus.out_ready     = 1'b0;
    bus.valid_in      = 1'b1;
    bus.patch_in_flat = rand_patch();
    step();
    bus.patch_in_flat = rand_patch();
    step();
    chk("ovf_in_ready_third", bus.in_ready, 0);
    bus.patch_in_flat = rand_patch();
    step();
    bus.valid_in = 1'b0;
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_valid", bus.out_valid, 1);
    drain(40);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("ovf_cleared", overflow_err, 0);

    // Full buffer, final row popping while a patch arrives: dropped.
    bus.out_ready = 1'b0;
    push_patch(rand_patch());
    push_patch(rand_patch());
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("pp_full_row5", bus.row_idx, 5);
    push_patch(rand_patch());
    chk("pp_full_ovf", overflow_err, 1);
    chk("pp_full_next_row", bus.row_idx, 0);
    // One entry, final row popping while a patch arrives: accepted.
    for (int i = 0; i < 5; i++) step();
    chk("pp_one_row5", bus.row_idx, 5);
    push_patch(ramp_patch());
    chk("pp_one_valid", bus.out_valid, 1);
    chk("pp_one_row0", bus.row_idx, 0);
    chk("pp_one_in_ready", bus.in_ready, 1);
    chk("pp_one_col5", col(5), 5);
    drain(20);

    // clear_err wins over a simultaneous overflow.
    bus.out_ready = 1'b0;
    push_patch(rand_patch());
    push_patch(rand_patch());
    clear_err = 1'b1;
    push_patch(rand_patch());
    clear_err = 1'b0;
    chk("clr_priority", overflow_err, 0);

    // Reset mid-drain with two patches buffered and the flag set.
    push_patch(rand_patch());
    chk("rst_mid_ovf_set", overflow_err, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rst_mid_row3", bus.row_idx, 3);
    rst_n = 1'b0;
    step();
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_row_idx", bus.row_idx, 0);
    chk("rst_mid_ovf", overflow_err, 0);
    rst_n = 1'b1;
    push_patch(ramp_patch());
    chk("rst_mid_fresh_row0", bus.row_idx, 0);
    chk("rst_mid_fresh_col5", col(5), 5);
    drain(20);

    // Random traffic, including occasional resets and error clears.
    for (int i = 0; i < 3000; i++) begin
      bus.valid_in      = ($urandom % 10) < 4;
      bus.patch_in_flat = rand_patch();
      bus.out_ready     = ($urandom % 10) < 6;
      clear_err         = ($urandom % 40) == 0;
      rst_n             = !(($urandom % 500) == 0);
      step();
    end
    rst_n        = 1'b1;
    bus.valid_in = 1'b0;
    clear_err    = 1'b0;
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
